// File: rtl/instruction_memory.sv
// Loadable instruction store: LOAD/RUN controller with registered single-cycle fetch.
// Define INSTRUCTION_MEMORY_PARITY_EN to store and check one even-parity bit per word.
module instruction_memory #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH      = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  input  logic                  reload,
  input  logic                  fetch_valid,
  input  logic [ADDR_WIDTH-1:0] fetch_address,
  output logic                  fetch_ready,
  output logic                  instruction_valid,
  output logic [DATA_WIDTH-1:0] instruction_data_output,
  output logic                  fetch_fault,
  output logic                  parity_error
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CMP_W = (ADDR_WIDTH > CNT_W) ? ADDR_WIDTH : CNT_W;
`ifdef INSTRUCTION_MEMORY_PARITY_EN
  localparam int unsigned MEM_W = DATA_WIDTH + 1;
`else
  localparam int unsigned MEM_W = DATA_WIDTH;
`endif
  localparam logic [CNT_W-1:0] LAST_PTR = CNT_W'(DEPTH - 1);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] load_count;
  logic [CNT_W-1:0] next_count;
  logic             load_accept;
  logic             fetch_accept;
  logic             fetch_in_range;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] rd_idx;
  logic [MEM_W-1:0] wr_word;
  logic [MEM_W-1:0] rd_word;

  logic [MEM_W-1:0] mem [DEPTH];

  // Next-state and handshake decode; reload always wins over load/fetch traffic.
  always_comb begin
    next_state   = state;
    next_count   = load_count;
    load_accept  = 1'b0;
    fetch_accept = 1'b0;
    case (state)
      ST_LOAD: begin
        if (reload) begin
          next_count = '0;
        end else if (load_valid) begin
          load_accept = 1'b1;
          next_count  = load_count + CNT_W'(1);
          if (load_last || (load_count == LAST_PTR)) begin
            next_state = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (reload) begin
          next_state = ST_LOAD;
          next_count = '0;
        end else if (fetch_valid) begin
          fetch_accept = 1'b1;
        end
      end
      default: begin
        next_state = ST_LOAD;
        next_count = '0;
      end
    endcase
  end

  // Write pointer doubles as load_count: it never wraps because LOAD exits at DEPTH-1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_LOAD;
      load_count  <= '0;
      load_ready  <= 1'b1;
      fetch_ready <= 1'b0;
    end else begin
      state       <= next_state;
      load_count  <= next_count;
      load_ready  <= (next_state == ST_LOAD);
      fetch_ready <= (next_state == ST_RUN);
    end
  end

  assign wr_idx = PTR_W'(load_count);
`ifdef INSTRUCTION_MEMORY_PARITY_EN
  assign wr_word = {^load_data, load_data};
`else
  assign wr_word = load_data;
`endif

  // Storage is deliberately not reset; load_count alone decides what is fetchable.
  always_ff @(posedge clock) begin
    if (load_accept) begin
      mem[wr_idx] <= wr_word;
    end
  end

  assign fetch_in_range = (CMP_W'(fetch_address) < CMP_W'(load_count));
  assign rd_idx         = fetch_in_range ? PTR_W'(fetch_address) : '0;
  assign rd_word        = mem[rd_idx];

  // Registered fetch response: data holds between pulses, fault only with a pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instruction_valid       <= 1'b0;
      instruction_data_output <= '0;
      fetch_fault             <= 1'b0;
    end else begin
      instruction_valid <= fetch_accept;
      fetch_fault       <= 1'b0;
      if (fetch_accept) begin
        fetch_fault             <= ~fetch_in_range;
        instruction_data_output <= fetch_in_range ? rd_word[DATA_WIDTH-1:0] : '0;
      end
    end
  end

`ifdef INSTRUCTION_MEMORY_PARITY_EN
  // Stored word plus parity bit must XOR to zero for an intact entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      parity_error <= 1'b0;
    end else begin
      parity_error <= fetch_accept && fetch_in_range && (^rd_word);
    end
  end
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_memory.sv
// Directed bench for instruction_memory (DEPTH=4): load, fetch, faults, reload and reset.
module tb_instruction_memory;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  logic          clock;
  logic          reset;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_last;
  logic          load_ready;
  logic          reload;
  logic          fetch_valid;
  logic [AW-1:0] fetch_address;
  logic          fetch_ready;
  logic          instruction_valid;
  logic [DW-1:0] instruction_data_output;
  logic          fetch_fault;
  logic          parity_error;

  int n_checks = 0;
  int n_errors = 0;

  instruction_memory #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH     (4)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .load_valid             (load_valid),
    .load_data              (load_data),
    .load_last              (load_last),
    .load_ready             (load_ready),
    .reload                 (reload),
    .fetch_valid            (fetch_valid),
    .fetch_address          (fetch_address),
    .fetch_ready            (fetch_ready),
    .instruction_valid      (instruction_valid),
    .instruction_data_output(instruction_data_output),
    .fetch_fault            (fetch_fault),
    .parity_error           (parity_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load_word(input logic [DW-1:0] data, input logic last);
    load_valid = 1'b1;
    load_data  = data;
    load_last  = last;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [AW-1:0] addr,
                       input logic [DW-1:0] exp_data, input logic exp_fault);
    fetch_valid   = 1'b1;
    fetch_address = addr;
    step();
    fetch_valid = 1'b0;
    check({tag, "_valid"}, 64'(instruction_valid), 64'd1);
    check({tag, "_data"}, 64'(instruction_data_output), 64'(exp_data));
    check({tag, "_fault"}, 64'(fetch_fault), 64'(exp_fault));
    check({tag, "_perr"}, 64'(parity_error), 64'd0);
  endtask

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    reload = 1'b0; fetch_valid = 1'b0; fetch_address = '0;
    step();
    step();
    check("rst_load_ready", 64'(load_ready), 64'd1);
    check("rst_fetch_ready", 64'(fetch_ready), 64'd0);
    check("rst_valid", 64'(instruction_valid), 64'd0);
    check("rst_data", 64'(instruction_data_output), 64'd0);
    check("rst_fault", 64'(fetch_fault), 64'd0);
    check("rst_perr", 64'(parity_error), 64'd0);
    reset = 1'b0;
    step();

    // Three-word program, last on word 3
    load_word(32'h2000_0000, 1'b0);
    load_word(32'h5BA0_0001, 1'b0);
    check("ld_ready_before_last", 64'(load_ready), 64'd1);
    load_word(32'h6BA0_0000, 1'b1);
    check("ld_ready_after_last", 64'(load_ready), 64'd0);
    check("run_fetch_ready", 64'(fetch_ready), 64'd1);

    fetch("f1", 32'd1, 32'h5BA0_0001, 1'b0);
    step();
    check("idle_valid", 64'(instruction_valid), 64'd0);
    check("idle_hold_data", 64'(instruction_data_output), 64'h5BA0_0001);
    check("idle_fault", 64'(fetch_fault), 64'd0);

    fetch("f3_unloaded", 32'd3, 32'h0, 1'b1);
    fetch("f_big", 32'h0000_0100, 32'h0, 1'b1);
    fetch("f_max", 32'hFFFF_FFFF, 32'h0, 1'b1);
    step();
    check("fault_clears", 64'(fetch_fault), 64'd0);

    // Back-to-back fetches
    fetch("b2b0", 32'd0, 32'h2000_0000, 1'b0);
    fetch("b2b1", 32'd1, 32'h5BA0_0001, 1'b0);
    fetch("b2b2", 32'd2, 32'h6BA0_0000, 1'b0);
    step();
    check("b2b_end_valid", 64'(instruction_valid), 64'd0);

    // Reload together with a fetch: fetch is dropped
    reload = 1'b1; fetch_valid = 1'b1; fetch_address = 32'd0;
    step();
    reload = 1'b0; fetch_valid = 1'b0;
    check("rl_no_resp", 64'(instruction_valid), 64'd0);
    check("rl_fetch_ready", 64'(fetch_ready), 64'd0);
    check("rl_load_ready", 64'(load_ready), 64'd1);
    load_word(32'hFFFF_FFFF, 1'b1);
    check("rl_run", 64'(fetch_ready), 64'd1);
    fetch("rl_f0", 32'd0, 32'hFFFF_FFFF, 1'b0);
    fetch("rl_f1_stale", 32'd1, 32'h0, 1'b1);

    // Fetch accepted just before reload still answers
    fetch_valid = 1'b1; fetch_address = 32'd0;
    step();
    fetch_valid = 1'b0; reload = 1'b1;
    check("pre_rl_valid", 64'(instruction_valid), 64'd1);
    check("pre_rl_data", 64'(instruction_data_output), 64'hFFFF_FFFF);
    step();
    reload = 1'b0;
    check("pre_rl_load", 64'(load_ready), 64'd1);

    // Reload in LOAD discards its word and restarts at 0
    load_word(32'hAAAA_AAAA, 1'b0);
    load_valid = 1'b1; load_data = 32'hBBBB_BBBB; reload = 1'b1;
    step();
    reload = 1'b0; load_valid = 1'b0;
    check("rl_in_load_ready", 64'(load_ready), 64'd1);

    // Fill all four entries with last held low
    load_word(32'h1111_0000, 1'b0);
    load_word(32'h2222_0001, 1'b0);
    load_word(32'h3333_0002, 1'b0);
    check("full_still_load", 64'(load_ready), 64'd1);
    load_word(32'h4444_0003, 1'b0);
    check("full_run", 64'(load_ready), 64'd0);
    check("full_fetch_ready", 64'(fetch_ready), 64'd1);
    load_word(32'h5555_0004, 1'b0);
    check("fifth_ignored", 64'(load_ready), 64'd0);
    fetch("full_f3", 32'd3, 32'h4444_0003, 1'b0);
    fetch("full_f0", 32'd0, 32'h1111_0000, 1'b0);
    fetch("full_f4", 32'd4, 32'h0, 1'b1);
    fetch("full_f3b", 32'd3, 32'h4444_0003, 1'b0);

    // Asynchronous reset in the middle of a load
    reload = 1'b1;
    step();
    reload = 1'b0;
    load_valid = 1'b1; load_data = 32'h9999_9999; load_last = 1'b0;
    step();
    #2;
    reset = 1'b1;
    #1;
    check("arst_load_ready", 64'(load_ready), 64'd1);
    check("arst_fetch_ready", 64'(fetch_ready), 64'd0);
    check("arst_valid", 64'(instruction_valid), 64'd0);
    check("arst_data", 64'(instruction_data_output), 64'd0);
    check("arst_fault", 64'(fetch_fault), 64'd0);
    load_valid = 1'b0;
    step();
    reset = 1'b0;
    step();
    load_word(32'h1234_5678, 1'b1);
    check("post_rst_run", 64'(fetch_ready), 64'd1);
    fetch("post_rst_f0", 32'd0, 32'h1234_5678, 1'b0);
    fetch("post_rst_f1", 32'd1, 32'h0, 1'b1);

`ifdef INSTRUCTION_MEMORY_PARITY_EN
    // Corrupt one stored data bit at address 0
    dut.mem[0][0] = ~dut.mem[0][0];
    fetch_valid = 1'b1; fetch_address = 32'd0;
    step();
    fetch_valid = 1'b0;
    check("par_valid", 64'(instruction_valid), 64'd1);
    check("par_err", 64'(parity_error), 64'd1);
    check("par_fault", 64'(fetch_fault), 64'd0);
    check("par_data", 64'(instruction_data_output), 64'h1234_5679);
    step();
    check("par_err_clears", 64'(parity_error), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instruction_memory.md
INSTRUCTION_MEMORY -- requirements
Module: instruction_memory

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning instruction word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning fetch address width; addresses are word addresses.
REQ-003 SHALL have parameter DEPTH, default 32, meaning number of storable words (2 to 2^ADDR_WIDTH).
REQ-004 SHALL have port clock  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port load_valid  input  1  load word present on load_data.
REQ-007 SHALL have port load_data  input  DATA_WIDTH  instruction word to store.
REQ-008 SHALL have port load_last  input  1  qualifies the final word of a program load.
REQ-009 SHALL have port load_ready  output  1  block accepts a load word this cycle.
REQ-010 SHALL have port reload  input  1  single-cycle request to discard the program and re-enter loading.
REQ-011 SHALL have port fetch_valid  input  1  fetch request present.
REQ-012 SHALL have port fetch_address  input  ADDR_WIDTH  word address to fetch.
REQ-013 SHALL have port fetch_ready  output  1  block accepts a fetch this cycle.
REQ-014 SHALL have port instruction_valid  output  1  one-cycle pulse: instruction_data_output updated.
REQ-015 SHALL have port instruction_data_output  output  DATA_WIDTH  fetched word.
REQ-016 SHALL have port fetch_fault  output  1  accompanies instruction_valid when the fetch address was not loaded.
REQ-017 SHALL have port parity_error  output  1  accompanies instruction_valid when stored parity mismatches.

Function
REQ-018 SHALL implement a two-state machine LOAD and RUN; reset enters LOAD.
REQ-019 In LOAD, load_ready SHALL be 1 and fetch_ready 0; in RUN, load_ready SHALL be 0 and fetch_ready 1.
REQ-020 A load word SHALL be accepted when load_valid and load_ready are both 1, written at the internal write pointer, and the pointer incremented.
REQ-021 The block SHALL keep load_count = number of words accepted since entering LOAD, width ceil(log2(DEPTH+1)).
REQ-022 LOAD SHALL move to RUN on the cycle after accepting a word with load_last=1, or after accepting the word at pointer DEPTH-1 regardless of load_last; the pointer SHALL NOT wrap.
REQ-023 A fetch SHALL be accepted when fetch_valid and fetch_ready are both 1; the read is registered, so instruction_valid pulses exactly one cycle after acceptance, giving one fetch per cycle at full throughput.
REQ-024 If fetch_address >= load_count, the response SHALL carry fetch_fault=1 and instruction_data_output=0; the memory SHALL NOT be indexed out of range.
REQ-025 instruction_data_output, fetch_fault and parity_error SHALL hold their values between responses; fetch_fault and parity_error SHALL be 0 whenever instruction_valid is 0.
REQ-026 reload=1 in RUN SHALL move to LOAD next cycle, clear the pointer and load_count, and take priority over a simultaneous fetch, which SHALL NOT be accepted; reload in LOAD SHALL restart the pointer at 0 and discard that cycle's load word.
REQ-027 A fetch accepted in the cycle before reload SHALL still produce its response.

Reset
REQ-028 Reset SHALL asynchronously set state=LOAD, pointer=0, load_count=0, instruction_valid=0, instruction_data_output=0, fetch_fault=0, parity_error=0.
REQ-029 Reset SHALL NOT clear memory contents; words become fetchable only after they are reloaded, per REQ-024.
REQ-030 Reset asserted mid-load SHALL abandon the load; the next load starts at address 0.

Configuration
REQ-031 With INSTRUCTION_MEMORY_PARITY_EN defined, each entry SHALL store one extra even-parity bit computed at load, and an in-range fetch with mismatched parity SHALL raise parity_error with its response while still returning the stored data.
REQ-032 Without INSTRUCTION_MEMORY_PARITY_EN, no parity storage SHALL exist and parity_error SHALL be constant 0.

Verification
REQ-033 Reset, load 3 words 0x20000000, 0x5BA00001, 0x6BA00000 with last on word 3 -> load_ready drops after the cycle that accepts word 3; fetch addr 1 -> next cycle instruction_valid=1, data 0x5BA00001, fault 0.
REQ-034 After the 3-word load, fetch addr 3 -> response fault=1, data 0.
REQ-035 DEPTH=4, load 4 words with load_last held 0 -> RUN entered; a 5th offered word is not accepted; fetch addr 3 returns word 4.
REQ-036 Back-to-back fetches 0,1,2 on consecutive cycles -> three consecutive instruction_valid pulses with matching data.
REQ-037 In RUN, assert reload and fetch_valid together -> fetch not accepted, fetch_ready=0 next cycle, then a fetch of addr 0 after reloading one word 0xFFFFFFFF returns 0xFFFFFFFF.
REQ-038 With INSTRUCTION_MEMORY_PARITY_EN, force one stored bit flip at addr 0 and fetch it -> parity_error=1 and fault=0; reset mid-load -> all outputs 0 immediately, load_ready=1.
